// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA/CPU framebuffer memory arbiter.
package vga_fb_pkg;

    localparam int unsigned AW_DEF     = 12;
    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned FDEPTH_DEF = 4;

    localparam logic [11:0] FB_BASE = 12'hC00;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VGA_WAIT = 2'd1,
        CPU_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vga_fb_wfifo.sv
// Posted-write FIFO holding {addr, data} store entries for the arbiter.
module vga_fb_wfifo
    import vga_fb_pkg::*;
#(
    parameter int unsigned W     = AW_DEF + DW_DEF,
    parameter int unsigned DEPTH = FDEPTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] store [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) store[wr_ptr[PW-1:0]] <= din;
    end

    assign dout  = store[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[PW], rd_ptr[PW-1:0]});

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port memory arbiter: VGA word fetches first, CPU loads next, posted CPU stores drained when idle.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned FDEPTH = FDEPTH_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,
    output logic          vga_stale,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q
);

    arb_state_t    state;
    arb_state_t    state_next;
    logic [AW-1:0] tag;
    logic [AW-1:0] fetched_addr;
    logic          fetched_valid;
    logic [DW-1:0] rdata_q;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [AW+DW-1:0] head;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;

    vga_fb_wfifo #(
        .W     (AW + DW),
        .DEPTH (FDEPTH)
    ) u_wfifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({cpu_addr, cpu_wdata}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign {head_addr, head_data} = head;
    assign vga_stale = !fetched_valid || (vga_addr != fetched_addr);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (vga_stale) begin
                    mem_addr   = vga_addr;
                    state_next = VGA_WAIT;
                end else if (cpu_re && !cpu_we && empty) begin
                    mem_addr   = cpu_addr;
                    state_next = CPU_WAIT;
                end else if (!empty) begin
                    pop       = 1'b1;
                    mem_addr  = head_addr;
                    mem_wdata = head_data;
                    mem_we    = 1'b1;
                end
            end
            VGA_WAIT: state_next = IDLE;
            CPU_WAIT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        // The memory port is combinational from state, so hold it quiet while reset is applied.
        if (reset) begin
            pop       = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_we    = 1'b0;
        end
    end

    // A full FIFO still accepts a store in a cycle where it is also popping.
    assign push      = cpu_we && (!full || pop);
    assign cpu_stall = cpu_we ? (full && !pop) : (cpu_re && (state != CPU_WAIT));
    assign cpu_rdata = (state == CPU_WAIT) ? mem_q : rdata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tag           <= '0;
            fetched_addr  <= '0;
            fetched_valid <= 1'b0;
            vga_data      <= '0;
            rdata_q       <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && vga_stale) tag <= vga_addr;
            if (state == VGA_WAIT) begin
                vga_data      <= mem_q;
                fetched_addr  <= tag;
                fetched_valid <= 1'b1;
            end else if (pop && fetched_valid && (head_addr == fetched_addr)) begin
                fetched_valid <= 1'b0;
            end
            if (state == CPU_WAIT) rdata_q <= mem_q;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a synchronous RAM model and a write-port scoreboard.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] vga_addr = FB_BASE;
    logic [31:0] vga_data;
    logic        vga_stale;
    logic [11:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_q;

    vga_fb_arbiter #(.AW(12), .DW(32), .FDEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_stale (vga_stale),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input logic [11:0] a);
        return {8'hA5, 4'h0, a, 8'h5A};
    endfunction

    logic [31:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_q <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_vga[$];

    // Scoreboard on the memory write port: every write must be the oldest accepted store.
    always @(negedge clock) begin
        if (!reset && mem_we) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", {20'h0, mem_addr, mem_wdata}, 64'h0);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_order", {20'h0, mem_addr, mem_wdata}, {20'h0, w.addr, w.data});
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic do_fetch(input logic [11:0] a, input int exp_lat);
        int lat;
        cyc();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        vga_addr = a;
        exp_vga.push_back(pat(a));
        lat = 0;
        smp();
        while (vga_stale && lat < 10) begin
            cyc();
            smp();
            lat++;
        end
        chk("vga_latency", 64'(lat), 64'(exp_lat));
        chk("vga_data", {32'h0, vga_data}, {32'h0, exp_vga.pop_front()});
    endtask

    task automatic do_store(input logic [11:0] a, input logic [31:0] d);
        int n;
        cyc();
        cpu_re = 1'b0;
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        n = 0;
        smp();
        while (cpu_stall && n < 20) begin
            cyc();
            smp();
            n++;
        end
        chk("store_accept", {63'h0, cpu_stall}, 64'h0);
        exp_wr.push_back('{a, d});
    endtask

    task automatic do_load(input logic [11:0] v, input logic [11:0] a, input logic [31:0] exp,
                           input int exp_stall, input logic [11:0] first_addr);
        int n;
        logic [31:0] e;
        cyc();
        cpu_we = 1'b0;
        vga_addr = v;
        cpu_re = 1'b1;
        cpu_addr = a;
        exp_rd.push_back(exp);
        n = 0;
        smp();
        chk("load_first_addr", {52'h0, mem_addr}, {52'h0, first_addr});
        while (cpu_stall && n < 20) begin
            cyc();
            smp();
            n++;
        end
        e = exp_rd.pop_front();
        chk("load_stall_cycles", 64'(n), 64'(exp_stall));
        chk("load_rdata", {32'h0, cpu_rdata}, {32'h0, e});
        cyc();
        cpu_re = 1'b0;
        smp();
        chk("load_rdata_hold", {32'h0, cpu_rdata}, {32'h0, e});
    endtask

    typedef struct {
        logic [11:0] vga;
        int          exp_lat;
        logic [11:0] ld;
        logic [31:0] exp_ld;
    } vec_t;
    vec_t vecs[6];

    typedef struct {
        logic [11:0] vga;
        logic        exp_stall;
    } fill_t;
    fill_t fill[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        vecs[0] = '{12'hC01, 2, 12'h010, pat(12'h010)};
        vecs[1] = '{12'hC01, 0, 12'h7FF, pat(12'h7FF)};
        vecs[2] = '{12'hFFF, 2, 12'h000, pat(12'h000)};
        vecs[3] = '{12'h000, 2, 12'hFFF, pat(12'hFFF)};
        vecs[4] = '{12'hC00, 2, 12'hC00, pat(12'hC00)};
        vecs[5] = '{12'hC00, 0, 12'h123, pat(12'h123)};
        fill[0] = '{12'hC10, 1'b0};
        fill[1] = '{12'hC10, 1'b0};
        fill[2] = '{12'hC11, 1'b0};
        fill[3] = '{12'hC11, 1'b0};
        fill[4] = '{12'hC10, 1'b1};
        fill[5] = '{12'hC10, 1'b1};
        fill[6] = '{12'hC10, 1'b0};

        // Reset values.
        smp();
        chk("rst_vga_data", {32'h0, vga_data}, 64'h0);
        chk("rst_vga_stale", {63'h0, vga_stale}, 64'h1);
        chk("rst_cpu_rdata", {32'h0, cpu_rdata}, 64'h0);
        chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
        chk("rst_mem_addr", {52'h0, mem_addr}, 64'h0);

        // First fetch after reset.
        cyc();
        reset = 1'b0;
        smp();
        chk("first_mem_addr", {52'h0, mem_addr}, {52'h0, FB_BASE});
        chk("first_stale_c1", {63'h0, vga_stale}, 64'h1);
        cyc();
        smp();
        chk("first_stale_c2", {63'h0, vga_stale}, 64'h1);
        cyc();
        smp();
        chk("first_stale_c3", {63'h0, vga_stale}, 64'h0);
        chk("first_vga_data", {32'h0, vga_data}, {32'h0, pat(FB_BASE)});

        for (int i = 0; i < 6; i++) begin
            do_fetch(vecs[i].vga, vecs[i].exp_lat);
            do_load(vecs[i].vga, vecs[i].ld, vecs[i].exp_ld, 1, vecs[i].ld);
        end

        // Back-to-back stores while VGA refetches block draining: fifth store stalls until a pop.
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            vga_addr = fill[k].vga;
            cpu_we = 1'b1;
            cpu_addr = 12'h100 + 12'(idx);
            cpu_wdata = 32'hD000_0000 + 32'(idx);
            smp();
            chk("fill_stall", {63'h0, cpu_stall}, {63'h0, fill[k].exp_stall});
            if (!cpu_stall) begin
                exp_wr.push_back('{cpu_addr, cpu_wdata});
                idx++;
            end
        end
        chk("fill_accepted", 64'(idx), 64'd5);
        cyc();
        cpu_we = 1'b0;
        n = 0;
        smp();
        while (exp_wr.size() != 0 && n < 20) begin
            cyc();
            smp();
            n++;
        end
        chk("fill_drained", 64'(exp_wr.size()), 64'd0);
        for (int i = 0; i < 5; i++)
            chk("fill_mem", {32'h0, mem[12'h100 + 12'(i)]}, {32'h0, 32'hD000_0000 + 32'(i)});

        // Store then load of the same address: load waits for the drain and sees the new data.
        do_store(12'hC05, 32'h1234_5678);
        do_load(12'hC10, 12'hC05, 32'h1234_5678, 2, 12'hC05);

        // VGA change together with a load: VGA fetch goes first.
        do_load(12'hC20, 12'h050, pat(12'h050), 3, 12'hC20);
        do_fetch(12'hC20, 0);

        // Store to the displayed word forces a refetch.
        do_fetch(12'hC30, 2);
        do_store(12'hC30, 32'hCAFE_F00D);
        cyc();
        cpu_we = 1'b0;
        smp();
        chk("inv_write", {63'h0, mem_we}, 64'h1);
        chk("inv_stale_before", {63'h0, vga_stale}, 64'h0);
        cyc();
        smp();
        chk("inv_stale_after", {63'h0, vga_stale}, 64'h1);
        chk("inv_refetch_addr", {52'h0, mem_addr}, 64'hC30);
        cyc();
        smp();
        cyc();
        smp();
        chk("inv_refetch_stale", {63'h0, vga_stale}, 64'h0);
        chk("inv_refetch_data", {32'h0, vga_data}, 64'hCAFE_F00D);

        // Reset during VGA_WAIT with a queued store: everything returns to reset values.
        cyc();
        vga_addr = 12'hC40;
        cpu_we = 1'b1;
        cpu_addr = 12'h200;
        cpu_wdata = 32'hBAD0_0200;
        smp();
        chk("rstmid_issue_addr", {52'h0, mem_addr}, 64'hC40);
        chk("rstmid_store_accept", {63'h0, cpu_stall}, 64'h0);
        exp_wr.push_back('{12'h200, 32'hBAD0_0200});
        cyc();
        cpu_we = 1'b0;
        reset = 1'b1;
        smp();
        exp_wr.delete();
        chk("rstmid_vga_data", {32'h0, vga_data}, 64'h0);
        chk("rstmid_vga_stale", {63'h0, vga_stale}, 64'h1);
        chk("rstmid_mem_we", {63'h0, mem_we}, 64'h0);
        chk("rstmid_mem_addr", {52'h0, mem_addr}, 64'h0);
        chk("rstmid_cpu_rdata", {32'h0, cpu_rdata}, 64'h0);
        cyc();
        reset = 1'b0;
        smp();
        chk("rstmid_idle_fetch", {52'h0, mem_addr}, 64'hC40);
        repeat (10) begin
            cyc();
            smp();
        end
        chk("rstmid_refetch_data", {32'h0, vga_data}, {32'h0, pat(12'hC40)});
        chk("rstmid_store_lost", {32'h0, mem[12'h200]}, {32'h0, pat(12'h200)});
        chk("final_wr_queue", 64'(exp_wr.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
